issue_unit: RTL and testbench

ISSUE_UNIT -- requirements
Module: issue_unit

---
 rtl/issue_unit.sv | 209 ++++++++++++++++++++
 tb/tb_issue_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// -----------------------------------------------------------------------------
// issue_unit
// In-order issue stage between an instruction queue and the execute stage.
// Pops the queue head when its source registers are free, resolves the
// destination register, tracks in-flight writers in a pending-register
// scoreboard and presents the issued instruction on a valid/ready handshake.
//
// Optional feature macro: ISSUE_STALL_CNT_EN
//   defined   -> iu_o_stall_cnt counts cycles spent in STALL (saturating)
//   undefined -> iu_o_stall_cnt is tied to 0 and no counter register exists
//
// Ports
//   iu_clk, iu_rst            clock, async active-low reset
//   iu_i_empty                queue empty flag (head fields valid when 0)
//   iu_i_pc/opcode/imm        queue head fields
//   iu_i_addr_rs/rt/rd        queue head register addresses
//   iu_i_reg_dst/reg_write/jal queue head control bits
//   iu_o_re                   queue pop strobe (combinational)
//   iu_o_valid, iu_i_ready    handshake toward execute
//   iu_o_pc/opcode/imm/addr_rs/addr_rt, iu_o_dest, iu_o_wen  issued instruction
//   iu_i_wb_en, iu_i_wb_addr  writeback, clears a pending bit
//   iu_i_flush                squash issued and pending state
//   iu_o_stall_cnt            saturating hazard stall cycle count
// -----------------------------------------------------------------------------
module issue_unit (
  input  logic        iu_clk,
  input  logic        iu_rst,
  input  logic        iu_i_empty,
  input  logic [31:0] iu_i_pc,
  input  logic [5:0]  iu_i_opcode,
  input  logic [15:0] iu_i_imm,
  input  logic [4:0]  iu_i_addr_rs,
  input  logic [4:0]  iu_i_addr_rt,
  input  logic [4:0]  iu_i_addr_rd,
  input  logic        iu_i_reg_dst,
  input  logic        iu_i_reg_write,
  input  logic        iu_i_jal,
  output logic        iu_o_re,
  output logic        iu_o_valid,
  input  logic        iu_i_ready,
  output logic [31:0] iu_o_pc,
  output logic [5:0]  iu_o_opcode,
  output logic [15:0] iu_o_imm,
  output logic [4:0]  iu_o_addr_rs,
  output logic [4:0]  iu_o_addr_rt,
  output logic [4:0]  iu_o_dest,
  output logic        iu_o_wen,
  input  logic        iu_i_wb_en,
  input  logic [4:0]  iu_i_wb_addr,
  input  logic        iu_i_flush,
  output logic [15:0] iu_o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pending;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [5:0]  r_opcode;
  logic [15:0] r_imm;
  logic [4:0]  r_addr_rs;
  logic [4:0]  r_addr_rt;
  logic [4:0]  r_dest;
  logic        r_wen;

  logic [4:0]  w_dest;
  logic        w_wen;
  logic        w_hazard;
  logic        w_pop;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_pending_nxt;

  // Destination resolution for the queue head.
  always_comb begin
    w_dest = 5'd0;
    if (iu_i_jal) begin
      w_dest = 5'd31;
    end else if (iu_i_reg_dst) begin
      w_dest = iu_i_addr_rd;
    end else begin
      w_dest = iu_i_addr_rt;
    end
    w_wen = iu_i_reg_write & (w_dest != 5'd0);
  end

  // RAW hazard on the head; register 0 is excluded explicitly as well as by the
  // scoreboard never holding bit 0.
  always_comb begin
    w_hazard = 1'b0;
    if (!iu_i_empty) begin
      w_hazard = ((iu_i_addr_rs != 5'd0) && r_pending[iu_i_addr_rs]) ||
                 ((iu_i_addr_rt != 5'd0) && r_pending[iu_i_addr_rt]);
    end else begin
      w_hazard = 1'b0;
    end
  end

  // Pop strobe; gated by reset so nothing is consumed while held in reset.
  always_comb begin
    w_pop = iu_rst & (r_state == ST_RUN) & ~iu_i_empty & ~w_hazard &
            (~r_valid | iu_i_ready) & ~iu_i_flush;
  end

  // Scoreboard next value: set is applied after clear so an issue to the same
  // register as a writeback keeps the bit set. Writebacks in FLUSH are dropped.
  always_comb begin
    w_clr_mask = 32'd0;
    w_set_mask = 32'd0;
    if (iu_i_wb_en && (iu_i_wb_addr != 5'd0) && (r_state != ST_FLUSH)) begin
      w_clr_mask[iu_i_wb_addr] = 1'b1;
    end else begin
      w_clr_mask = 32'd0;
    end
    if (w_pop && w_wen) begin
      w_set_mask[w_dest] = 1'b1;
    end else begin
      w_set_mask = 32'd0;
    end
    w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
  end

  // Issue FSM.
  always_ff @(posedge iu_clk or negedge iu_rst) begin
    if (!iu_rst) begin
      r_state <= ST_RUN;
    end else if (iu_i_flush) begin
      r_state <= ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN:   r_state <= w_hazard ? ST_STALL : ST_RUN;
        ST_STALL: r_state <= w_hazard ? ST_STALL : ST_RUN;
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // Pending-register scoreboard.
  always_ff @(posedge iu_clk or negedge iu_rst) begin
    if (!iu_rst) begin
      r_pending <= 32'd0;
    end else if (iu_i_flush) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Issued-instruction register: load on pop, retire on handshake, squash on flush.
  always_ff @(posedge iu_clk or negedge iu_rst) begin
    if (!iu_rst) begin
      r_valid   <= 1'b0;
      r_pc      <= 32'd0;
      r_opcode  <= 6'd0;
      r_imm     <= 16'd0;
      r_addr_rs <= 5'd0;
      r_addr_rt <= 5'd0;
      r_dest    <= 5'd0;
      r_wen     <= 1'b0;
    end else if (iu_i_flush) begin
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_valid   <= 1'b1;
      r_pc      <= iu_i_pc;
      r_opcode  <= iu_i_opcode;
      r_imm     <= iu_i_imm;
      r_addr_rs <= iu_i_addr_rs;
      r_addr_rt <= iu_i_addr_rt;
      r_dest    <= w_dest;
      r_wen     <= w_wen;
    end else if (r_valid && iu_i_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles spent in STALL; only reset clears it.
  always_ff @(posedge iu_clk or negedge iu_rst) begin
    if (!iu_rst) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == ST_STALL) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign iu_o_stall_cnt = r_stall_cnt;
`else
  assign iu_o_stall_cnt = 16'd0;
`endif

  assign iu_o_re      = w_pop;
  assign iu_o_valid   = r_valid;
  assign iu_o_pc      = r_pc;
  assign iu_o_opcode  = r_opcode;
  assign iu_o_imm     = r_imm;
  assign iu_o_addr_rs = r_addr_rs;
  assign iu_o_addr_rt = r_addr_rt;
  assign iu_o_dest    = r_dest;
  assign iu_o_wen     = r_wen;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit. A small queue model feeds the head fields and
// advances on iu_o_re; expected values are hand-derived per step.
module tb_issue_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_dst;
    logic        reg_write;
    logic        jal;
  } ent_t;

`ifdef ISSUE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        iu_clk;
  logic        iu_rst;
  logic        iu_i_empty;
  logic        iu_o_re;
  logic        iu_o_valid;
  logic        iu_i_ready;
  logic [31:0] iu_o_pc;
  logic [5:0]  iu_o_opcode;
  logic [15:0] iu_o_imm;
  logic [4:0]  iu_o_addr_rs;
  logic [4:0]  iu_o_addr_rt;
  logic [4:0]  iu_o_dest;
  logic        iu_o_wen;
  logic        iu_i_wb_en;
  logic [4:0]  iu_i_wb_addr;
  logic        iu_i_flush;
  logic [15:0] iu_o_stall_cnt;

  ent_t        q_mem [0:15];
  logic [3:0]  q_rd;
  logic [3:0]  q_wr;
  logic        q_drop;
  ent_t        head;

  int n_err;
  int n_checks;

  assign head       = q_mem[q_rd];
  assign iu_i_empty = (q_rd == q_wr);

  issue_unit dut (
    .iu_clk        (iu_clk),
    .iu_rst        (iu_rst),
    .iu_i_empty    (iu_i_empty),
    .iu_i_pc       (head.pc),
    .iu_i_opcode   (head.op),
    .iu_i_imm      (head.imm),
    .iu_i_addr_rs  (head.rs),
    .iu_i_addr_rt  (head.rt),
    .iu_i_addr_rd  (head.rd),
    .iu_i_reg_dst  (head.reg_dst),
    .iu_i_reg_write(head.reg_write),
    .iu_i_jal      (head.jal),
    .iu_o_re       (iu_o_re),
    .iu_o_valid    (iu_o_valid),
    .iu_i_ready    (iu_i_ready),
    .iu_o_pc       (iu_o_pc),
    .iu_o_opcode   (iu_o_opcode),
    .iu_o_imm      (iu_o_imm),
    .iu_o_addr_rs  (iu_o_addr_rs),
    .iu_o_addr_rt  (iu_o_addr_rt),
    .iu_o_dest     (iu_o_dest),
    .iu_o_wen      (iu_o_wen),
    .iu_i_wb_en    (iu_i_wb_en),
    .iu_i_wb_addr  (iu_i_wb_addr),
    .iu_i_flush    (iu_i_flush),
    .iu_o_stall_cnt(iu_o_stall_cnt)
  );

  initial begin
    iu_clk = 1'b0;
    forever #5 iu_clk = ~iu_clk;
  end

  // Queue read pointer: advances on pop, or jumps to the write pointer on drop.
  always @(posedge iu_clk) begin
    if (q_drop) q_rd <= q_wr;
    else if (iu_o_re) q_rd <= q_rd + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iu_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [5:0] op, input logic [15:0] imm,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic reg_dst, input logic reg_write, input logic jal);
    q_mem[q_wr] = '{pc, op, imm, rs, rt, rd, reg_dst, reg_write, jal};
    q_wr = q_wr + 4'd1;
  endtask

  function automatic logic [31:0] sc(input logic [31:0] v);
    return CNT_EN ? v : 32'd0;
  endfunction

  initial begin
    n_err = 0;
    n_checks = 0;
    iu_rst = 1'b0;
    q_drop = 1'b1;
    q_wr = 4'd0;
    iu_i_ready = 1'b1;
    iu_i_flush = 1'b0;
    iu_i_wb_en = 1'b0;
    iu_i_wb_addr = 5'd0;
    for (int i = 0; i < 16; i++) q_mem[i] = '0;

    // Reset state, with a non-empty queue that must not be popped
    tick(); tick();
    push(32'h99, 6'h01, 16'h0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    #1;
    check("rst_re", iu_o_re, 32'd0);
    check("rst_valid", iu_o_valid, 32'd0);
    check("rst_pc", iu_o_pc, 32'd0);
    check("rst_dest", iu_o_dest, 32'd0);
    check("rst_wen", iu_o_wen, 32'd0);
    check("rst_pending", dut.r_pending, 32'd0);
    check("rst_stall", iu_o_stall_cnt, 32'd0);
    tick();
    @(negedge iu_clk);
    iu_rst = 1'b1;
    q_drop = 1'b0;
    tick();
    check("idle_valid", iu_o_valid, 32'd0);
    check("idle_re", iu_o_re, 32'd0);

    // Basic issue with rd destination
    push(32'h10, 6'h08, 16'h1234, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
    #1;
    check("iss_re", iu_o_re, 32'd1);
    tick();
    check("iss_valid", iu_o_valid, 32'd1);
    check("iss_pc", iu_o_pc, 32'h10);
    check("iss_op", iu_o_opcode, 32'h08);
    check("iss_imm", iu_o_imm, 32'h1234);
    check("iss_dest", iu_o_dest, 32'd1);
    check("iss_wen", iu_o_wen, 32'd1);
    check("iss_pending", dut.r_pending, 32'h2);
    check("iss_re_empty", iu_o_re, 32'd0);

    // RAW hazard on rs=1, resolved by writeback
    push(32'h14, 6'h09, 16'h0, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    #1;
    check("haz_re", iu_o_re, 32'd0);
    tick();
    check("haz_valid", iu_o_valid, 32'd0);
    check("haz_re1", iu_o_re, 32'd0);
    check("haz_cnt0", iu_o_stall_cnt, 32'd0);
    tick();
    check("haz_cnt1", iu_o_stall_cnt, sc(32'd1));
    tick();
    iu_i_wb_en = 1'b1;
    iu_i_wb_addr = 5'd1;
    #1;
    check("haz_re_wb", iu_o_re, 32'd0);
    tick();
    iu_i_wb_en = 1'b0;
    check("wb_pending", dut.r_pending, 32'd0);
    check("haz_cnt3", iu_o_stall_cnt, sc(32'd3));
    #1;
    check("stall_exit_re", iu_o_re, 32'd0);
    tick();
    check("haz_cnt4", iu_o_stall_cnt, sc(32'd4));
    check("run_re", iu_o_re, 32'd1);
    tick();
    check("haz_iss_valid", iu_o_valid, 32'd1);
    check("haz_iss_pc", iu_o_pc, 32'h14);
    check("haz_iss_dest", iu_o_dest, 32'd2);
    check("haz_iss_pending", dut.r_pending, 32'h4);
    check("haz_cnt_hold", iu_o_stall_cnt, sc(32'd4));
    iu_i_wb_en = 1'b1;
    iu_i_wb_addr = 5'd2;
    tick();
    iu_i_wb_en = 1'b0;
    check("drain_valid", iu_o_valid, 32'd0);
    check("drain_pending", dut.r_pending, 32'd0);

    // Backpressure then back-to-back issue
    iu_i_ready = 1'b0;
    push(32'h10, 6'h00, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    push(32'h14, 6'h00, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    push(32'h18, 6'h00, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("bp_re_first", iu_o_re, 32'd1);
    tick();
    check("bp_pc0", iu_o_pc, 32'h10);
    check("bp_re_hold", iu_o_re, 32'd0);
    tick();
    check("bp_valid_hold", iu_o_valid, 32'd1);
    check("bp_pc_hold", iu_o_pc, 32'h10);
    check("bp_wen", iu_o_wen, 32'd0);
    check("bp_re_hold2", iu_o_re, 32'd0);
    iu_i_ready = 1'b1;
    #1;
    check("b2b_re", iu_o_re, 32'd1);
    tick();
    check("b2b_pc1", iu_o_pc, 32'h14);
    check("b2b_valid1", iu_o_valid, 32'd1);
    tick();
    check("b2b_pc2", iu_o_pc, 32'h18);
    check("b2b_valid2", iu_o_valid, 32'd1);
    tick();
    check("b2b_valid_end", iu_o_valid, 32'd0);

    // jal to r31; writeback to 31 in the same cycle as a second jal issue
    push(32'h20, 6'h03, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1;
    check("jal_re", iu_o_re, 32'd1);
    tick();
    check("jal_dest", iu_o_dest, 32'd31);
    check("jal_wen", iu_o_wen, 32'd1);
    check("jal_op", iu_o_opcode, 32'h03);
    check("jal_pending", dut.r_pending, 32'h8000_0000);
    push(32'h24, 6'h03, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    iu_i_wb_en = 1'b1;
    iu_i_wb_addr = 5'd31;
    #1;
    check("jal2_re", iu_o_re, 32'd1);
    tick();
    check("jal2_pc", iu_o_pc, 32'h24);
    check("set_wins", dut.r_pending, 32'h8000_0000);
    iu_i_wb_addr = 5'd0;
    tick();
    check("wb_r0", dut.r_pending, 32'h8000_0000);
    check("jal_drain", iu_o_valid, 32'd0);
    iu_i_wb_addr = 5'd5;
    tick();
    check("wb_not_pending", dut.r_pending, 32'h8000_0000);
    iu_i_wb_addr = 5'd31;
    tick();
    iu_i_wb_en = 1'b0;
    check("wb_r31", dut.r_pending, 32'd0);

    // Flush with valid=1 and pending={1,5}
    push(32'h30, 6'h00, 16'h0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
    push(32'h34, 6'h00, 16'h0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    check("fl_pc_a", iu_o_pc, 32'h30);
    check("fl_pend_a", dut.r_pending, 32'h2);
    tick();
    check("fl_pc_b", iu_o_pc, 32'h34);
    check("fl_pend_b", dut.r_pending, 32'h22);
    iu_i_ready = 1'b0;
    push(32'h38, 6'h00, 16'h0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    #1;
    check("fl_re_bp", iu_o_re, 32'd0);
    iu_i_flush = 1'b1;
    iu_i_ready = 1'b1;
    #1;
    check("fl_re", iu_o_re, 32'd0);
    tick();
    iu_i_flush = 1'b0;
    check("fl_valid", iu_o_valid, 32'd0);
    check("fl_pending", dut.r_pending, 32'd0);
    #1;
    check("fl_state_re", iu_o_re, 32'd0);
    tick();
    check("fl_valid2", iu_o_valid, 32'd0);
    check("fl_resume_re", iu_o_re, 32'd1);
    tick();
    check("fl_resume_pc", iu_o_pc, 32'h38);
    check("fl_resume_dest", iu_o_dest, 32'd3);
    check("fl_resume_pend", dut.r_pending, 32'h8);
    check("fl_cnt", iu_o_stall_cnt, sc(32'd4));

    // Async reset while holding an instruction under backpressure
    iu_i_wb_en = 1'b1;
    iu_i_wb_addr = 5'd3;
    push(32'h40, 6'h00, 16'h0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    iu_i_wb_en = 1'b0;
    iu_i_ready = 1'b0;
    check("ar_pc", iu_o_pc, 32'h40);
    check("ar_pending", dut.r_pending, 32'h10);
    push(32'h44, 6'h00, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    iu_rst = 1'b0;
    q_drop = 1'b1;
    #1;
    check("ar_valid", iu_o_valid, 32'd0);
    check("ar_pc0", iu_o_pc, 32'd0);
    check("ar_op0", iu_o_opcode, 32'd0);
    check("ar_dest0", iu_o_dest, 32'd0);
    check("ar_wen0", iu_o_wen, 32'd0);
    check("ar_re0", iu_o_re, 32'd0);
    check("ar_pend0", dut.r_pending, 32'd0);
    check("ar_cnt0", iu_o_stall_cnt, 32'd0);
    tick();
    check("ar_hold_re", iu_o_re, 32'd0);
    @(negedge iu_clk);
    iu_rst = 1'b1;
    q_drop = 1'b0;
    iu_i_ready = 1'b1;
    tick();
    check("ar_post_valid", iu_o_valid, 32'd0);
    check("ar_post_re", iu_o_re, 32'd0);
    push(32'h48, 6'h0A, 16'h00FF, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    #1;
    check("ar_new_re", iu_o_re, 32'd1);
    tick();
    check("ar_new_pc", iu_o_pc, 32'h48);
    check("ar_new_valid", iu_o_valid, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
